// File: rtl/noc_pkg.sv
// noc_pkg: shared types and helpers for the router output allocation logic.
package noc_pkg;
    typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} alloc_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Callers size-cast the result down to their own vector width.
    function automatic logic [31:0] onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set match bit at or after the pointer.
import noc_pkg::*;

module rr_arbiter #(
    parameter int NUM_INPUTS = 5,
    parameter int IW = idx_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] i_match,
    input  logic [IW-1:0]         i_rr_pointer,
    output logic [IW-1:0]         o_winner,
    output logic                  o_any_match
);
    always_comb begin
        o_winner = '0;
        o_any_match = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            automatic int idx = (int'(i_rr_pointer) + k) % NUM_INPUTS;
            if (!o_any_match && i_match[idx]) begin
                o_winner = IW'(idx);
                o_any_match = 1'b1;
            end
        end
    end
endmodule

// File: rtl/route_reservation_allocator.sv
// route_reservation_allocator: per-output round-robin route reservation with lock until relieve.
import noc_pkg::*;

module route_reservation_allocator #(
    parameter int NUM_INPUTS    = 5,
    parameter int REQUEST_WIDTH = 3,
    parameter int OUTPUT_INDEX  = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_INPUTS-1:0]             routeReserveRequestValid,
    input  logic [NUM_INPUTS*REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic [NUM_INPUTS-1:0]             routeRelieve,
    output logic [NUM_INPUTS-1:0]             routeReserveStatus,
    output logic [NUM_INPUTS-1:0]             outputSelect,
    output logic                              outputBusy
);
    localparam int IW = idx_width(NUM_INPUTS);

    alloc_state_t          r_state;
    logic [IW-1:0]         r_owner;
    logic [IW-1:0]         r_rr_pointer;
    logic [NUM_INPUTS-1:0] w_match;
    logic [IW-1:0]         w_winner;
    logic                  w_any_match;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            w_match[i] = routeReserveRequestValid[i] &&
                         (routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(OUTPUT_INDEX));
    end

    rr_arbiter #(.NUM_INPUTS(NUM_INPUTS), .IW(IW)) u_arb (
        .i_match      (w_match),
        .i_rr_pointer (r_rr_pointer),
        .o_winner     (w_winner),
        .o_any_match  (w_any_match)
    );

    // Grants only leave Idle, so every release costs one Idle cycle before the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= ALLOC_IDLE;
            r_owner            <= '0;
            r_rr_pointer       <= '0;
            routeReserveStatus <= '0;
            outputSelect       <= '0;
            outputBusy         <= 1'b0;
        end else begin
            routeReserveStatus <= '0;
            case (r_state)
                ALLOC_IDLE: if (w_any_match) begin
                    r_state            <= ALLOC_LOCKED;
                    r_owner            <= w_winner;
                    routeReserveStatus <= NUM_INPUTS'(onehot(32'(w_winner)));
                    outputSelect       <= NUM_INPUTS'(onehot(32'(w_winner)));
                    outputBusy         <= 1'b1;
                end
                default: if (routeRelieve[r_owner]) begin
                    r_state      <= ALLOC_IDLE;
                    r_rr_pointer <= (32'(r_owner) == NUM_INPUTS - 1) ? '0 : r_owner + 1'b1;
                    outputSelect <= '0;
                    outputBusy   <= 1'b0;
                end
            endcase
        end
    end
endmodule
